// File: rtl/lpddr2_responder.sv
// Single-port LPDDR2 stand-in: one outstanding read or write with fixed latency,
// level-sensitive request/ack handshake and sticky error flags.
module lpddr2_responder #(
    parameter int ADDR_BITS     = 10,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic        mem_clk,
    input  logic        rst,
    input  logic [26:0] lpddr2_address,
    input  logic [31:0] lpddr2_write_data,
    input  logic        lpddr2_rreq,
    input  logic        lpddr2_wreq,
    output logic [31:0] lpddr2_read_data,
    output logic        ack,
    output logic        busy,
    output logic        err_oob,
    output logic        err_collision
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] READ_COUNT  = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WRITE_COUNT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   addr_reg, addr_next;
    logic [31:0]            wdata_reg, wdata_next;
    logic [3:0]             count_reg, count_next;
    logic                   oob_reg, oob_next;
    logic                   err_oob_reg, err_oob_next;
    logic                   err_collision_reg, err_collision_next;
    logic [31:0]            read_data_reg;
    logic                   mem_we;
    logic                   rd_fire;
    logic                   addr_oob;

    logic [31:0] mem [DEPTH];

    // Any set bit above the implemented index range marks the request out of range.
    generate
        if (ADDR_BITS < 27) begin : g_oob
            assign addr_oob = |lpddr2_address[26:ADDR_BITS];
        end else begin : g_no_oob
            assign addr_oob = 1'b0;
        end
    endgenerate

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            wdata_reg         <= '0;
            count_reg         <= '0;
            oob_reg           <= 1'b0;
            err_oob_reg       <= 1'b0;
            err_collision_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            addr_reg          <= addr_next;
            wdata_reg         <= wdata_next;
            count_reg         <= count_next;
            oob_reg           <= oob_next;
            err_oob_reg       <= err_oob_next;
            err_collision_reg <= err_collision_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        addr_next          = addr_reg;
        wdata_next         = wdata_reg;
        count_next         = count_reg;
        oob_next           = oob_reg;
        err_oob_next       = err_oob_reg;
        err_collision_next = err_collision_reg;
        mem_we             = 1'b0;
        rd_fire            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (lpddr2_wreq) begin
                    // A simultaneous read is dropped in favour of the write.
                    addr_next          = lpddr2_address[ADDR_BITS-1:0];
                    wdata_next         = lpddr2_write_data;
                    count_next         = WRITE_COUNT;
                    oob_next           = addr_oob;
                    err_oob_next       = err_oob_reg | addr_oob;
                    err_collision_next = err_collision_reg | lpddr2_rreq;
                    state_next         = WRITE_WAIT;
                end else if (lpddr2_rreq) begin
                    addr_next    = lpddr2_address[ADDR_BITS-1:0];
                    count_next   = READ_COUNT;
                    oob_next     = addr_oob;
                    err_oob_next = err_oob_reg | addr_oob;
                    state_next   = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (count_reg == 4'd0) begin
                    rd_fire    = 1'b1;
                    state_next = DONE;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            WRITE_WAIT: begin
                if (count_reg == 4'd0) begin
                    mem_we     = ~oob_reg;
                    state_next = DONE;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            DONE: begin
                if (!lpddr2_rreq && !lpddr2_wreq) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Backing store is never cleared; reset only blocks a commit in the same cycle.
    always_ff @(posedge mem_clk) begin
        if (mem_we && !rst) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            read_data_reg <= '0;
        end else if (rd_fire) begin
            read_data_reg <= oob_reg ? 32'hDEAD_BEEF : mem[addr_reg];
        end
    end

    assign lpddr2_read_data = read_data_reg;
    assign ack              = (state_reg == DONE);
    assign busy             = (state_reg != IDLE);
    assign err_oob          = err_oob_reg;
    assign err_collision    = err_collision_reg;

endmodule

// File: doc/lpddr2_responder.md
LPDDR2_RESPONDER -- requirements
Module: lpddr2_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning log2 of backing-store depth in 32-bit words.
REQ-002 SHALL have parameter READ_LATENCY, default 3, meaning cycles from request accept to read data update; legal range 1..15.
REQ-003 SHALL have parameter WRITE_LATENCY, default 2, meaning cycles from request accept to write commit; legal range 1..15.
REQ-004 SHALL have port mem_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the mem_clk rising edge.
REQ-006 SHALL have port lpddr2_address  input  27  word address from the CPU-side initiator.
REQ-007 SHALL have port lpddr2_write_data  input  32  write payload.
REQ-008 SHALL have port lpddr2_rreq  input  1  read request, level.
REQ-009 SHALL have port lpddr2_wreq  input  1  write request, level.
REQ-010 SHALL have port lpddr2_read_data  output  32  registered read result.
REQ-011 SHALL have port ack  output  1  transaction complete, held until both requests drop.
REQ-012 SHALL have port busy  output  1  high in WAIT and DONE states.
REQ-013 SHALL have port err_oob  output  1  sticky out-of-range address flag.
REQ-014 SHALL have port err_collision  output  1  sticky simultaneous read/write request flag.

Function
REQ-015 SHALL implement FSM states IDLE, READ_WAIT, WRITE_WAIT, DONE.
REQ-016 SHALL, in IDLE with lpddr2_wreq=1 at edge N, capture address and write data, load the latency counter, and enter WRITE_WAIT.
REQ-017 SHALL, in IDLE with lpddr2_rreq=1 and lpddr2_wreq=0 at edge N, capture address, load the latency counter, and enter READ_WAIT.
REQ-018 SHALL, when both requests are high in IDLE, service the write only and set err_collision.
REQ-019 SHALL ignore all changes to address, data, and request inputs while in READ_WAIT or WRITE_WAIT.
REQ-020 SHALL update lpddr2_read_data to mem[captured address] and assert ack at edge N+READ_LATENCY, entering DONE.
REQ-021 SHALL commit the write to mem at edge N+WRITE_LATENCY, assert ack, and enter DONE.
REQ-022 SHALL, in DONE, hold ack=1 and move to IDLE (ack=0) on the first edge where lpddr2_rreq=0 and lpddr2_wreq=0; at least one IDLE cycle precedes the next accept.
REQ-023 SHALL treat any address with a nonzero bit above ADDR_BITS-1 as out of range: reads return 32'hDEADBEEF, writes are dropped, err_oob is set; ack timing is unchanged.
REQ-024 SHALL hold lpddr2_read_data at its last value until the next read completes; writes do not alter it.
REQ-025 SHALL keep err_oob and err_collision set until reset.
REQ-026 SHALL derive busy combinationally from state: busy=1 in all states except IDLE.

Reset
REQ-027 SHALL, on rst=1 at an edge, force state IDLE, lpddr2_read_data=0, ack=0, err_oob=0, err_collision=0, latency counter=0.
REQ-028 SHALL abort any in-flight transaction on reset: a pending write is not committed.
REQ-029 SHALL leave backing-store contents unchanged by reset.
REQ-030 SHALL give reset priority over every request presented in the same cycle.

Verification
REQ-031 SHALL cover: write 32'hCAFEF00D to address 5, drop wreq after ack, then read address 5 -> ack at accept+2 for the write, then lpddr2_read_data=32'hCAFEF00D with ack at accept+3 for the read.
REQ-032 SHALL cover: assert rreq and wreq together to address 7 with data 32'h12345678 -> write is serviced, err_collision=1, and a later read of address 7 returns 32'h12345678.
REQ-033 SHALL cover: read address 27'h400 with ADDR_BITS=10 -> lpddr2_read_data=32'hDEADBEEF and err_oob=1; a write to 27'h400 leaves address 0 unchanged.
REQ-034 SHALL cover: assert rst one cycle after accepting a write of 32'hAAAA5555 to address 3 -> no commit; the prior value at address 3 is read back and all outputs are 0 after reset.
REQ-035 SHALL cover: hold rreq high after ack for 4 cycles -> ack stays 1 and no new read starts; rreq low then high -> second read starts only after one IDLE cycle.
REQ-036 SHALL cover: change lpddr2_address during READ_WAIT -> data returned is from the originally captured address.
